grf_writeback: RTL and testbench
================================

Name: grf_writeback

Overview:
- General register file for the single-cycle MIPS datapath.
- Owns the 32 architectural registers.
- Serves two combinational read ports: RD1 feeds ALU operand A; RD2 feeds the ALU-source select and the data-memory write path.
- Accepts one write-back per clock from the write-back stage.
- Emits a registered one-cycle write-log record per committed write, for the course-style trace checker.

Parameters:
- WIDTH, 32, data width of each register.
- AW, 5, register address width; register count is 2**AW.
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports; when 0 reads return the stored value only.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- RA1  input  AW  read address, port 1
- RA2  input  AW  read address, port 2
- RD1  output  WIDTH  read data, port 1 (combinational)
- RD2  output  WIDTH  read data, port 2 (combinational)
- WE  input  1  write enable
- WA  input  AW  write address
- WD  input  WIDTH  write data
- WPC  input  32  PC of the instruction performing the write (logging only)
- log_valid  output  1  registered pulse: one write committed last cycle
- log_pc  output  32  PC of the logged write
- log_addr  output  AW  register address of the logged write
- log_data  output  WIDTH  value written
- wr_count  output  32  number of committed writes since reset

Behaviour:
- Reset (reset=0, asynchronous): all registers clear to 0; log_valid=0; log_pc=0; log_addr=0; log_data=0; wr_count=0.
- Reset release: the module is synchronous to clk from the first rising edge with reset=1.
- Write commit: a write commits on a rising edge when reset=1, WE=1 and WA!=0.
- Commit effect: reg[WA] <= WD.
- Writes to address 0 are discarded; reg[0] reads 0 always.
- Read, stored path: RDn = (RAn==0) ? 0 : reg[RAn]. Purely combinational, zero latency.
- Read, bypass (BYPASS=1): if WE=1, WA!=0 and WA==RAn, then RDn=WD in the same cycle. Each port is checked independently; both ports may bypass at once.
- Read, no bypass (BYPASS=0): a new value is visible on the cycle after the commit edge.
- Log record: on every commit edge, log_valid<=1 and log_pc<=WPC, log_addr<=WA, log_data<=WD. On any other edge, log_valid<=0 and log_pc/log_addr/log_data hold their previous values.
- Log latency: exactly 1 cycle after the commit edge.
- Discarded write (WE=1, WA=0): not a commit. No log record, no count increment.
- wr_count: increments by 1 per commit; wraps modulo 2**32 (0xFFFFFFFF -> 0) with no flag.
- Reset mid-operation: an asserted reset overrides any coincident write. The register clears and the log pulse is dropped.
- Undriven WA/RA (X): no requirement beyond WE=0 being safe.

Decomposition:
- Shared package (or the project's common `define header):
  - GRF_AW = 5
  - GRF_WIDTH = 32
  - ZERO_REG = 5'd0
  - log record field widths
- Natural sub-module: grf_read_port. Holds the address decode, the $0 force and the bypass compare for one read port. Instantiated twice.
- Storage, the write decode and the log/count logic stay in the top module.

Test Plan:
- Reset and zero state: hold reset=0 for 3 cycles, release, read all 32 addresses -> every RD = 0, log_valid=0, wr_count=0.
- Basic write, BYPASS=1: WE=1, WA=8, WD=0x12345678, WPC=0x00003000.
  - Same cycle: RA1=8 gives RD1=0x12345678 (bypass).
  - Next cycle: log_valid=1, log_pc=0x3000, log_addr=8, log_data=0x12345678, wr_count=1.
- $0 protection: WE=1, WA=0, WD=0xFFFFFFFF, RA1=RA2=0 -> RD1=RD2=0 in the same cycle and after the edge; log_valid stays 0; wr_count unchanged.
- Dual-port and no-bypass: set BYPASS=0.
  - Write reg5=0xA, then WE=1, WA=5, WD=0xB with RA1=RA2=5 -> RD1=RD2=0xA that cycle, 0xB the next.
  - Back-to-back writes to regs 1..31 -> 31 consecutive log pulses, wr_count=31.
- Async reset mid-write: WE=1, WA=3, WD=0x55, reset=0 asserted between edges -> reg3 reads 0 immediately, no log pulse, wr_count=0.
- Counter wrap: force wr_count to 0xFFFFFFFF, then one commit -> wr_count=0; the log record is still emitted.

Source files
------------

// File: rtl/grf_writeback_pkg.sv
// grf_writeback_pkg
// Shared constants for the general register file and its write-log record.
//   GRF_AW / GRF_WIDTH : default address and data widths
//   ZERO_REG           : the hard-wired zero register ($0)
//   LOG_*_W            : widths of the write-log record fields
package grf_writeback_pkg;

    localparam int GRF_AW    = 5;
    localparam int GRF_WIDTH = 32;

    localparam logic [GRF_AW-1:0] ZERO_REG = 5'd0;

    localparam int LOG_PC_W   = 32;
    localparam int LOG_ADDR_W = GRF_AW;
    localparam int LOG_DATA_W = GRF_WIDTH;
    localparam int LOG_CNT_W  = 32;

endpackage

// File: rtl/grf_read_port.sv
// grf_read_port
// One combinational read port of the register file.
//   ra   : read address
//   regs : full register array from the storage in the top module
//   we   : write enable of the current write-back
//   wa   : write address of the current write-back
//   wd   : write data of the current write-back
//   rd   : read data ($0 forced to zero, optional same-cycle forwarding)
module grf_read_port
    import grf_writeback_pkg::*;
#(
    parameter int WIDTH  = GRF_WIDTH,
    parameter int AW     = GRF_AW,
    parameter int BYPASS = 1
) (
    input  logic [AW-1:0]    ra,
    input  logic [WIDTH-1:0] regs [2**AW],
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    output logic [WIDTH-1:0] rd
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

    logic fwd_hit;

    // A forwarded value must only come from a write that will really commit,
    // so the $0 check on the write address is part of the hit.
    assign fwd_hit = (BYPASS != 0) && we && (wa != ZERO_ADDR) && (wa == ra);

    // NOTE: every output of this always_comb gets a default first, so no
    // path through the block can leave rd unassigned and infer a latch.
    always_comb begin
        rd = '0;
        if (ra != ZERO_ADDR) begin
            rd = regs[ra];
        end
        if (fwd_hit) begin
            rd = wd;
        end
    end

endmodule

// File: rtl/grf_writeback.sv
// grf_writeback
// General register file for the single-cycle MIPS datapath: 2**AW registers,
// two combinational read ports, one write-back per clock, and a registered
// one-cycle write-log record per committed write.
//   clk       : system clock, rising edge
//   reset     : asynchronous, active-low reset
//   RA1/RD1   : read port 1 (ALU operand A)
//   RA2/RD2   : read port 2 (ALU source select / store data)
//   WE/WA/WD  : write-back enable, address, data
//   WPC       : PC of the writing instruction (logging only)
//   log_valid : one-cycle pulse, a write committed on the previous edge
//   log_pc/log_addr/log_data : fields of the last committed write
//   wr_count  : committed writes since reset, wraps modulo 2**32
module grf_writeback
    import grf_writeback_pkg::*;
#(
    parameter int WIDTH  = GRF_WIDTH,
    parameter int AW     = GRF_AW,
    parameter int BYPASS = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [AW-1:0]         RA1,
    input  logic [AW-1:0]         RA2,
    output logic [WIDTH-1:0]      RD1,
    output logic [WIDTH-1:0]      RD2,
    input  logic                  WE,
    input  logic [AW-1:0]         WA,
    input  logic [WIDTH-1:0]      WD,
    input  logic [LOG_PC_W-1:0]   WPC,
    output logic                  log_valid,
    output logic [LOG_PC_W-1:0]   log_pc,
    output logic [AW-1:0]         log_addr,
    output logic [WIDTH-1:0]      log_data,
    output logic [LOG_CNT_W-1:0]  wr_count
);

    localparam int              NREGS     = 2**AW;
    localparam logic [AW-1:0]   ZERO_ADDR = AW'(ZERO_REG);

    logic [WIDTH-1:0] regs [NREGS];
    logic             commit;

    // Writes to $0 are dropped here, so they neither update storage nor
    // produce a log record or a count increment.
    assign commit = WE && (WA != ZERO_ADDR);

    // NOTE: the register array is cleared by the asynchronous reset because
    // software relies on every register reading zero after reset; this keeps
    // it in flops rather than a RAM macro, which is expected for a 32-entry
    // MIPS register file.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            // NOTE: sequential state uses non-blocking assignment so every
            // flop samples pre-edge values regardless of statement order.
            regs[WA] <= WD;
        end
    end

    // Log record: the valid pulse lasts one cycle, the payload fields hold
    // the most recent committed write until the next one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            log_valid <= 1'b0;
            log_pc    <= '0;
            log_addr  <= '0;
            log_data  <= '0;
            wr_count  <= '0;
        end else begin
            log_valid <= commit;
            if (commit) begin
                log_pc   <= WPC;
                log_addr <= WA;
                log_data <= WD;
                wr_count <= wr_count + 1'b1;
            end
        end
    end

    grf_read_port #(
        .WIDTH  (WIDTH),
        .AW     (AW),
        .BYPASS (BYPASS)
    ) u_rd_port1 (
        .ra   (RA1),
        .regs (regs),
        .we   (WE),
        .wa   (WA),
        .wd   (WD),
        .rd   (RD1)
    );

    grf_read_port #(
        .WIDTH  (WIDTH),
        .AW     (AW),
        .BYPASS (BYPASS)
    ) u_rd_port2 (
        .ra   (RA2),
        .regs (regs),
        .we   (WE),
        .wa   (WA),
        .wd   (WD),
        .rd   (RD2)
    );

endmodule

// File: tb/tb_grf_writeback.sv
// tb_grf_writeback
// Self-checking bench for grf_writeback. Two instances share all inputs:
// one with forwarding enabled and one without. Read data is checked right
// after inputs settle; log records are pushed into a queue by the driver and
// popped by a separate monitor after each rising edge.
module tb_grf_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  RA1, RA2, WA;
    logic        WE;
    logic [31:0] WD, WPC;

    logic [31:0] rd1_b, rd2_b, rd1_nb, rd2_nb;
    logic        lv_b, lv_nb;
    logic [31:0] lpc_b, lpc_nb, ldata_b, ldata_nb, cnt_b, cnt_nb;
    logic [4:0]  laddr_b, laddr_nb;

    always #5 clk = ~clk;

    grf_writeback #(.WIDTH(32), .AW(5), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .RA1(RA1), .RA2(RA2), .RD1(rd1_b), .RD2(rd2_b),
        .WE(WE), .WA(WA), .WD(WD), .WPC(WPC),
        .log_valid(lv_b), .log_pc(lpc_b), .log_addr(laddr_b), .log_data(ldata_b),
        .wr_count(cnt_b)
    );

    grf_writeback #(.WIDTH(32), .AW(5), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .RA1(RA1), .RA2(RA2), .RD1(rd1_nb), .RD2(rd2_nb),
        .WE(WE), .WA(WA), .WD(WD), .WPC(WPC),
        .log_valid(lv_nb), .log_pc(lpc_nb), .log_addr(laddr_nb), .log_data(ldata_nb),
        .wr_count(cnt_nb)
    );

    typedef struct {
        bit          valid;
        logic [31:0] pc;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] count;
    } log_exp_t;

    log_exp_t exp_q[$];

    // Reference model: architectural register contents and last log record.
    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;
    logic [31:0] m_pc, m_data;
    logic [4:0]  m_addr;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_cnt  = 32'd0;
        m_pc   = 32'd0;
        m_addr = 5'd0;
        m_data = 32'd0;
    endfunction

    // Architectural read: $0 is zero; with forwarding, a real pending write
    // to the same register is visible immediately.
    function automatic logic [31:0] model_rd(input bit fwd, input logic [4:0] ra,
                                             input bit we, input logic [4:0] wa,
                                             input logic [31:0] wd);
        if (ra == 5'd0) return 32'd0;
        if (fwd && we && wa == ra) return wd;
        return m_regs[ra];
    endfunction

    // One clock of stimulus: drive, check reads, update model, queue log.
    task automatic cycle(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [31:0] wpc, input logic [4:0] ra1, input logic [4:0] ra2);
        bit commit;
        @(negedge clk);
        WE = we; WA = wa; WD = wd; WPC = wpc; RA1 = ra1; RA2 = ra2;
        #1;
        check("rd1_bypass", rd1_b,  model_rd(1'b1, ra1, we, wa, wd));
        check("rd2_bypass", rd2_b,  model_rd(1'b1, ra2, we, wa, wd));
        check("rd1_stored", rd1_nb, model_rd(1'b0, ra1, we, wa, wd));
        check("rd2_stored", rd2_nb, model_rd(1'b0, ra2, we, wa, wd));
        commit = we && (wa != 5'd0);
        if (commit) begin
            m_regs[wa] = wd;
            m_cnt      = m_cnt + 32'd1;
            m_pc       = wpc;
            m_addr     = wa;
            m_data     = wd;
        end
        exp_q.push_back('{commit, m_pc, m_addr, m_data, m_cnt});
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
    endtask

    // Monitor: after each rising edge, compare the log interface of both
    // instances with the record queued for that edge.
    initial begin
        log_exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("log_valid",    {31'd0, lv_b},  {31'd0, e.valid});
                check("log_valid_nb", {31'd0, lv_nb}, {31'd0, e.valid});
                check("log_pc",       lpc_b,   e.pc);
                check("log_addr",     {27'd0, laddr_b}, {27'd0, e.addr});
                check("log_data",     ldata_b, e.data);
                check("wr_count",     cnt_b,   e.count);
                check("wr_count_nb",  cnt_nb,  e.count);
                check("log_data_nb",  ldata_nb, e.data);
            end
        end
    end

    // Time limit: the sequence below is bounded, this only guards a hang.
    initial begin
        #2_000_000;
        fails++;
        $display("FAIL timeout: simulation did not complete");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        logic [4:0]  wa, ra1, ra2;
        bit          we;

        reset = 1'b0;
        WE = 1'b0; WA = 5'd0; WD = 32'd0; WPC = 32'd0; RA1 = 5'd0; RA2 = 5'd0;
        model_clear();

        // Reset held for three cycles.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_log_valid", {31'd0, lv_b}, 32'd0);
        check("rst_wr_count",  cnt_b, 32'd0);
        check("rst_log_pc",    lpc_b, 32'd0);
        reset = 1'b1;

        // Every register reads zero after reset.
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 5'd0, 32'd0, 32'd0, 5'(2 * i), 5'(2 * i + 1));
        end

        // Basic write with same-cycle forwarding, log on the next edge.
        cycle(1'b1, 5'd8, 32'h1234_5678, 32'h0000_3000, 5'd8, 5'd0);
        idle_cycle();

        // Writes to $0 are discarded.
        cycle(1'b1, 5'd0, 32'hFFFF_FFFF, 32'h0000_3004, 5'd0, 5'd0);
        cycle(1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);

        // Dual-port read of a register being overwritten.
        cycle(1'b1, 5'd5, 32'h0000_000A, 32'h0000_3008, 5'd5, 5'd5);
        cycle(1'b1, 5'd5, 32'h0000_000B, 32'h0000_300C, 5'd5, 5'd5);
        cycle(1'b0, 5'd0, 32'd0, 32'd0, 5'd5, 5'd5);

        // Back-to-back writes to every register after a fresh reset.
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 1; i < 32; i++) begin
            cycle(1'b1, 5'(i), 32'hA000_0000 + 32'(i), 32'h0000_4000 + 32'(4 * i), 5'(i), 5'(i - 1));
        end
        idle_cycle();
        check("count_after_31", cnt_b, 32'd31);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 5'd0, 32'd0, 32'd0, 5'(2 * i), 5'(2 * i + 1));
        end

        // Randomized traffic, biased so reads often hit the written register.
        for (int n = 0; n < 300; n++) begin
            we  = ($urandom_range(0, 3) != 0);
            wa  = 5'($urandom_range(0, 31));
            ra1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
            ra2 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
            cycle(we, wa, $urandom, $urandom, ra1, ra2);
        end

        // Asynchronous reset in the middle of a write cycle.
        cycle(1'b1, 5'd3, 32'h0000_0077, 32'h0000_5000, 5'd3, 5'd3);
        @(negedge clk);
        WE = 1'b1; WA = 5'd3; WD = 32'h0000_0055; WPC = 32'h0000_5004; RA1 = 5'd3; RA2 = 5'd3;
        #2;
        reset = 1'b0;
        #1;
        model_clear();
        check("async_rst_reg3",      rd2_nb, 32'd0);
        check("async_rst_count",     cnt_b, 32'd0);
        check("async_rst_log_valid", {31'd0, lv_b}, 32'd0);
        exp_q.push_back('{1'b0, 32'd0, 5'd0, 32'd0, 32'd0});
        @(negedge clk);
        WE = 1'b0;
        reset = 1'b1;
        cycle(1'b0, 5'd0, 32'd0, 32'd0, 5'd3, 5'd8);

        // Counter wrap: preload the count one below wrap, then commit once.
        @(negedge clk);
        force dut.wr_count = 32'hFFFF_FFFF;
        force dut_nb.wr_count = 32'hFFFF_FFFF;
        #1;
        release dut.wr_count;
        release dut_nb.wr_count;
        m_cnt = 32'hFFFF_FFFF;
        cycle(1'b1, 5'd9, 32'hCAFE_F00D, 32'h0000_6000, 5'd9, 5'd9);
        idle_cycle();
        check("wrap_count", cnt_b, 32'd0);

        repeat (2) @(posedge clk);
        #2;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
